// File: rtl/fib_pkg.sv
// fib_pkg: shared definitions for the Fibonacci/Lucas sequencer.
//   fib_state_t    - sequencer control states
//   FIB_DEF_SEED0  - first term loaded by reset
//   FIB_DEF_SEED1  - second term loaded by reset
//   FIB_UNBOUNDED  - num_terms value that selects an endless run
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fib_state_t;

    localparam int FIB_DEF_SEED0 = 0;
    localparam int FIB_DEF_SEED1 = 1;
    localparam int FIB_UNBOUNDED = 0;

endpackage

// File: rtl/fib_step.sv
// fib_step: combinational recurrence step, sum = a + b.
// Optional feature macro: FIB_OVF_HALT_EN.
//   a, b         in   DATA_WIDTH  current operands
//   sum          out  DATA_WIDTH  a + b modulo 2^DATA_WIDTH
//   a_tag, b_tag in   1           overflow tags of the operands (macro only)
//   sum_tag      out  1           carry-out of this step or any tagged operand (macro only)
module fib_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
`ifdef FIB_OVF_HALT_EN
    input  logic                  a_tag,
    input  logic                  b_tag,
    output logic                  sum_tag,
`endif
    output logic [DATA_WIDTH-1:0] sum
);

`ifdef FIB_OVF_HALT_EN
    logic [DATA_WIDTH:0] sum_wide;

    // One extra bit so the carry-out is the overflow of this step.
    assign sum_wide = {1'b0, a} + {1'b0, b};
    assign sum      = sum_wide[DATA_WIDTH-1:0];
    // A term derived from an overflowed operand is itself invalid.
    assign sum_tag  = sum_wide[DATA_WIDTH] | a_tag | b_tag;
`else
    // Overflow is not tracked in this build: the sum wraps silently.
    assign sum = a + b;
`endif

endmodule

// File: rtl/fibonacci_sequencer.sv
// fibonacci_sequencer: generalised Fibonacci/Lucas term source on a valid/ready stream.
// Optional feature macro: FIB_OVF_HALT_EN (halt with ovf=1 instead of emitting a wrapped term).
//   clk        in   1           clock, all logic on posedge
//   resetn     in   1           synchronous active-low reset
//   start      in   1           load seeds and num_terms, begin a run
//   seed0      in   DATA_WIDTH  first term, sampled on start
//   seed1      in   DATA_WIDTH  second term, sampled on start
//   num_terms  in   CNT_WIDTH   terms to emit, 0 = unbounded
//   dout       out  DATA_WIDTH  current term
//   dout_valid out  1           dout holds a valid term
//   dout_ready in   1           consumer accepts dout
//   term_idx   out  CNT_WIDTH   0-based index of the term on dout
//   done       out  1           run complete, held until start or reset
//   ovf        out  1           run stopped on arithmetic overflow (macro only)
module fibonacci_sequencer
    import fib_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int DEF_SEED0  = FIB_DEF_SEED0,
    parameter int DEF_SEED1  = FIB_DEF_SEED1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed0,
    input  logic [DATA_WIDTH-1:0] seed1,
    input  logic [CNT_WIDTH-1:0]  num_terms,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [CNT_WIDTH-1:0]  term_idx,
`ifdef FIB_OVF_HALT_EN
    output logic                  ovf,
`endif
    output logic                  done
);

    fib_state_t            state;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] sum;
    logic [CNT_WIDTH-1:0]  n_terms;
    logic                  last_term;
`ifdef FIB_OVF_HALT_EN
    logic                  a_ovf;
    logic                  b_ovf;
    logic                  sum_ovf;
`endif

    fib_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .a       (a),
        .b       (b),
`ifdef FIB_OVF_HALT_EN
        .a_tag   (a_ovf),
        .b_tag   (b_ovf),
        .sum_tag (sum_ovf),
`endif
        .sum     (sum)
    );

    // The term on dout is the last one of a bounded run.
    assign last_term = (n_terms != CNT_WIDTH'(FIB_UNBOUNDED)) &&
                       (term_idx == n_terms - 1'b1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            a          <= DATA_WIDTH'(DEF_SEED0);
            b          <= DATA_WIDTH'(DEF_SEED1);
            n_terms    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            term_idx   <= '0;
            done       <= 1'b0;
`ifdef FIB_OVF_HALT_EN
            a_ovf      <= 1'b0;
            b_ovf      <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else if (start) begin
            // start overrides any handshake in the same cycle.
            state      <= RUN;
            a          <= seed0;
            b          <= seed1;
            n_terms    <= num_terms;
            dout       <= seed0;
            dout_valid <= 1'b1;
            term_idx   <= '0;
            done       <= 1'b0;
`ifdef FIB_OVF_HALT_EN
            a_ovf      <= 1'b0;
            b_ovf      <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (dout_ready) begin
                        if (last_term) begin
                            state      <= HALT;
                            dout_valid <= 1'b0;
                            done       <= 1'b1;
`ifdef FIB_OVF_HALT_EN
                        end else if (b_ovf) begin
                            // Next term wrapped: stop rather than emit it.
                            state      <= HALT;
                            dout_valid <= 1'b0;
                            done       <= 1'b1;
                            ovf        <= 1'b1;
`endif
                        end else begin
                            a        <= b;
                            b        <= sum;
                            dout     <= b;
                            term_idx <= term_idx + 1'b1;
`ifdef FIB_OVF_HALT_EN
                            a_ovf    <= b_ovf;
                            b_ovf    <= sum_ovf;
`endif
                        end
                    end
                end
                default: ; // IDLE and HALT wait for start
            endcase
        end
    end

endmodule

// File: tb/tb_fibonacci_sequencer.sv
module tb_fibonacci_sequencer;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [DW-1:0] seed0;
    logic [DW-1:0] seed1;
    logic [CW-1:0] num_terms;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [CW-1:0] term_idx;
    logic          done;
`ifdef FIB_OVF_HALT_EN
    logic          ovf;
`endif

    typedef struct {
        logic [DW-1:0] d;
        int            i;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_ovf;

    always #5 clk = ~clk;

    fibonacci_sequencer #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .seed0      (seed0),
        .seed1      (seed1),
        .num_terms  (num_terms),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .term_idx   (term_idx),
`ifdef FIB_OVF_HALT_EN
        .ovf        (ovf),
`endif
        .done       (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start and rebuild the scoreboard from a reference recurrence.
    task automatic do_start(input int s0, input int s1, input int n, input logic rdy);
        logic [DW:0]   s;
        logic [DW-1:0] ra, rb, na;
        logic          ta, tb, nta;
        int            lim;
        seed0      = DW'(s0);
        seed1      = DW'(s1);
        num_terms  = CW'(n);
        dout_ready = rdy;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        q.delete();
        exp_ovf = 1'b0;
        ra = DW'(s0); rb = DW'(s1); ta = 1'b0; tb = 1'b0;
        lim = (n == 0) ? 20 : n;
        for (int k = 0; k < lim; k++) begin
`ifdef FIB_OVF_HALT_EN
            if (ta) begin
                exp_ovf = 1'b1;
                break;
            end
`endif
            q.push_back('{d: ra, i: k});
            s   = {1'b0, ra} + {1'b0, rb};
            na  = rb;
            nta = tb;
            rb  = s[DW-1:0];
            tb  = s[DW] | ta | tb;
            ra  = na;
            ta  = nta;
        end
    endtask

    // Consume n terms with a repeating 4-cycle ready pattern, checking each cycle.
    task automatic run(input int n, input logic [3:0] pat);
        int hs = 0;
        int c  = 0;
        while (hs < n) begin
            if (c > 4 * n + 8) begin
                checks++;
                errors++;
                $error("FAIL run_timeout observed %0d expected %0d", hs, n);
                return;
            end
            dout_ready = pat[c % 4];
            chk("valid", {31'b0, dout_valid}, 32'd1);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL scoreboard_empty observed %0d expected %0d", dout, 0);
                return;
            end
            chk("dout", {24'b0, dout}, {24'b0, q[0].d});
            chk("term_idx", {16'b0, term_idx}, 32'(q[0].i[CW-1:0]));
            if (dout_ready) begin
                void'(q.pop_front());
                hs++;
            end
            tick();
            c++;
        end
        dout_ready = 1'b1;
    endtask

    task automatic chk_halted();
        chk("halt_done", {31'b0, done}, 32'd1);
        chk("halt_valid", {31'b0, dout_valid}, 32'd0);
`ifdef FIB_OVF_HALT_EN
        chk("halt_ovf", {31'b0, ovf}, {31'b0, exp_ovf});
`endif
    endtask

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        seed0      = '0;
        seed1      = '0;
        num_terms  = '0;
        dout_ready = 1'b1;
        tick();
        tick();
        chk("rst_dout", {24'b0, dout}, 32'd0);
        chk("rst_valid", {31'b0, dout_valid}, 32'd0);
        chk("rst_idx", {16'b0, term_idx}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
`ifdef FIB_OVF_HALT_EN
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
`endif
        resetn = 1'b1;
        tick();
        chk("idle_valid", {31'b0, dout_valid}, 32'd0);

        // Fibonacci, 8 terms back to back.
        do_start(0, 1, 8, 1'b1);
        run(8, 4'b1111);
        chk_halted();

        // Lucas, 6 terms.
        do_start(2, 1, 6, 1'b1);
        run(6, 4'b1111);
        chk_halted();

        // Back-pressure with ready pattern 1,0,0,1.
        do_start(0, 1, 10, 1'b1);
        run(10, 4'b1001);
        chk_halted();

        // Unbounded run across the 8-bit overflow point.
        do_start(0, 1, 0, 1'b1);
`ifdef FIB_OVF_HALT_EN
        chk("ovf_terms", 32'(q.size()), 32'd14);
        run(14, 4'b1111);
        chk_halted();
`else
        chk("wrap_terms", 32'(q.size()), 32'd20);
        run(20, 4'b1111);
        chk("wrap_valid", {31'b0, dout_valid}, 32'd1);
        chk("wrap_idx", {16'b0, term_idx}, 32'd20);
`endif

        // Reset in the middle of a run, then restart.
        do_start(0, 1, 0, 1'b1);
        run(4, 4'b1111);
        chk("pre_rst_idx", {16'b0, term_idx}, 32'd4);
        resetn = 1'b0;
        tick();
        chk("mid_rst_valid", {31'b0, dout_valid}, 32'd0);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        chk("mid_rst_idx", {16'b0, term_idx}, 32'd0);
        resetn = 1'b1;
        tick();
        chk("post_rst_valid", {31'b0, dout_valid}, 32'd0);
        do_start(0, 1, 5, 1'b1);
        run(5, 4'b1111);
        chk_halted();

        // start collides with a handshake at term 3.
        do_start(0, 1, 0, 1'b1);
        run(3, 4'b1111);
        chk("pre_restart_idx", {16'b0, term_idx}, 32'd3);
        do_start(5, 5, 4, 1'b1);
        run(4, 4'b1111);
        chk_halted();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
